// File: rtl/sram_bus_pkg.sv
// rtl/sram_bus_pkg.sv - shared types and constants for the SRAM bus responder
package sram_bus_pkg;
  localparam int DEF_DEPTH_W = 10;
  localparam int DEF_ADDR_W  = 20;

  localparam logic [15:0] CLEAR_WORD = 16'h0000;
  localparam logic [15:0] OOR_READ   = 16'h0000;

  typedef enum logic [1:0] {
    CLEAR,
    LOAD,
    SERVE
  } state_t;
endpackage

// File: rtl/sram_byte_ram.sv
// rtl/sram_byte_ram.sv - single-port 16-bit word RAM, per-byte write, write-first registered read
module sram_byte_ram #(
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [15:0]        wdata,
  input  logic               we_hi,
  input  logic               we_lo,
  output logic [15:0]        rdata
);
  logic [15:0] mem [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (we_hi) mem[addr][15:8] <= wdata[15:8];
    if (we_lo) mem[addr][7:0]  <= wdata[7:0];
  end

  // Bypass the written lanes so a same-edge write and read of one word returns the new value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= {we_hi ? wdata[15:8] : mem[addr][15:8],
                we_lo ? wdata[7:0]  : mem[addr][7:0]};
    end
  end
endmodule

// File: rtl/sram_bus_responder.sv
// rtl/sram_bus_responder.sv - on-chip stand-in for the async SRAM on the SLC-3 bus
module sram_bus_responder
  import sram_bus_pkg::*;
#(
  parameter int DEPTH_W = DEF_DEPTH_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               CE,
  input  logic               UB,
  input  logic               LB,
  input  logic               OE,
  input  logic               WE,
  input  logic [ADDR_W-1:0]  ADDR,
  inout  wire  [15:0]        Data,
  input  logic               Load_Valid,
  input  logic [DEPTH_W-1:0] Load_Addr,
  input  logic [15:0]        Load_Data,
  input  logic               Load_Done,
  output logic               Load_Ready,
  output logic               Busy,
  output logic               Err
);
  state_t             state, state_nxt;
  logic [DEPTH_W-1:0] clr_cnt;
  logic [DEPTH_W-1:0] ram_addr;
  logic [15:0]        ram_wdata, ram_rdata, out_word;
  logic               ram_we_hi, ram_we_lo;
  logic               oor, wr_req, rd_req, drive_hi, drive_lo;

  assign oor    = |ADDR[ADDR_W-1:DEPTH_W];
  assign wr_req = (state == SERVE) && !CE && !WE;
  assign rd_req = (state == SERVE) && !CE && !OE && WE;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_cnt == '1) state_nxt = LOAD;
      LOAD:    if (Load_Done)     state_nxt = SERVE;
      SERVE:   state_nxt = SERVE;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    Busy       = 1'b1;
    Load_Ready = 1'b0;
    ram_addr   = ADDR[DEPTH_W-1:0];
    ram_wdata  = Data;
    ram_we_hi  = 1'b0;
    ram_we_lo  = 1'b0;
    case (state)
      CLEAR: begin
        ram_addr  = clr_cnt;
        ram_wdata = CLEAR_WORD;
        ram_we_hi = 1'b1;
        ram_we_lo = 1'b1;
      end
      LOAD: begin
        Load_Ready = 1'b1;
        ram_addr   = Load_Addr;
        ram_wdata  = Load_Data;
        ram_we_hi  = Load_Valid;
        ram_we_lo  = Load_Valid;
      end
      SERVE: begin
        Busy      = 1'b0;
        ram_we_hi = wr_req && !oor && !UB;
        ram_we_lo = wr_req && !oor && !LB;
      end
      default: ;
    endcase
  end

  // Counter wraps to 0 on the same edge that leaves CLEAR
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)               clr_cnt <= '0;
    else if (state == CLEAR)  clr_cnt <= clr_cnt + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                          Err <= 1'b0;
    else if ((wr_req || rd_req) && oor)  Err <= 1'b1;
  end

  sram_byte_ram #(.DEPTH_W(DEPTH_W)) u_ram (
    .clk   (Clk),
    .rst_n (Reset),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .we_hi (ram_we_hi),
    .we_lo (ram_we_lo),
    .rdata (ram_rdata)
  );

  // Reset gates the drive directly so the bus floats without waiting for a clock
  assign out_word  = oor ? OOR_READ : ram_rdata;
  assign drive_hi  = Reset && rd_req && !UB;
  assign drive_lo  = Reset && rd_req && !LB;
  assign Data[15:8] = drive_hi ? out_word[15:8] : 8'bz;
  assign Data[7:0]  = drive_lo ? out_word[7:0]  : 8'bz;
endmodule

// File: tb/tb_sram_bus_responder.sv
// tb/tb_sram_bus_responder.sv - scoreboard bench for sram_bus_responder
module tb_sram_bus_responder;
  localparam logic [15:0] HIZ = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b1, ub = 1'b0, lb = 1'b0, oe = 1'b1, we = 1'b1;
  logic [19:0] addr = '0;
  logic        load_valid = 1'b0, load_done = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic        load_ready, busy, err;
  logic        tb_en = 1'b0;
  logic [15:0] tb_drv = '0;
  wire  [15:0] bus;

  assign bus = tb_en ? tb_drv : 16'bz;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (bus[i]);
  end

  always #5 clk = ~clk;

  sram_bus_responder dut (
    .Clk(clk), .Reset(rst_n), .CE(ce), .UB(ub), .LB(lb), .OE(oe), .WE(we),
    .ADDR(addr), .Data(bus), .Load_Valid(load_valid), .Load_Addr(load_addr),
    .Load_Data(load_data), .Load_Done(load_done), .Load_Ready(load_ready),
    .Busy(busy), .Err(err)
  );

  typedef struct {
    string       name;
    logic [15:0] data;
    logic        busy;
    logic        ready;
    logic        err;
  } exp_t;

  exp_t sb[$];
  logic sample = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic err_exp = 1'b0;

  always @(negedge clk) begin
    if (sample) begin
      exp_t e;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_underflow: sample with empty scoreboard");
      end else begin
        e = sb.pop_front();
        vectors++;
        if (bus !== e.data || busy !== e.busy || load_ready !== e.ready || err !== e.err) begin
          miscompares++;
          $display("FAIL %s: got data=%h busy=%b ready=%b err=%b, want data=%h busy=%b ready=%b err=%b",
                   e.name, bus, busy, load_ready, err, e.data, e.busy, e.ready, e.err);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input logic [15:0] d,
                            input logic b, input logic r, input logic e);
    exp_t x;
    x.name = name; x.data = d; x.busy = b; x.ready = r; x.err = e;
    sb.push_back(x);
    sample = 1'b1;
    @(negedge clk);
    #1;
    sample = 1'b0;
  endtask

  task automatic idle();
    ce = 1'b1; oe = 1'b1; we = 1'b1; ub = 1'b0; lb = 1'b0; tb_en = 1'b0;
  endtask

  task automatic bus_wr(input logic [19:0] a, input logic [15:0] d, input logic u, input logic l);
    ce = 1'b0; we = 1'b0; oe = 1'b1; ub = u; lb = l; addr = a; tb_drv = d; tb_en = 1'b1;
    step();
    idle();
  endtask

  task automatic bus_rd(input string name, input logic [19:0] a, input logic u, input logic l,
                        input logic [15:0] d);
    ce = 1'b0; oe = 1'b0; we = 1'b1; ub = u; lb = l; addr = a;
    step();
    expect_now(name, d, 1'b0, 1'b0, err_exp);
    idle();
  endtask

  initial begin
    step();
    expect_now("reset_state", HIZ, 1'b1, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    ce = 1'b0; oe = 1'b0; we = 1'b1; addr = 20'h00003;
    repeat (3) step();
    expect_now("clear_read_hiz", HIZ, 1'b1, 1'b0, 1'b0);
    idle();
    repeat (1020) step();
    expect_now("clear_cycle_1023", HIZ, 1'b1, 1'b0, 1'b0);
    step();
    expect_now("load_ready", HIZ, 1'b1, 1'b1, 1'b0);

    load_valid = 1'b1; load_addr = 10'h005; load_data = 16'h1234;
    step();
    load_addr = 10'h006; load_data = 16'hABCD; load_done = 1'b1;
    step();
    load_valid = 1'b0; load_done = 1'b0;

    bus_rd("rd_6", 20'h00006, 1'b0, 1'b0, 16'hABCD);
    bus_rd("rd_5", 20'h00005, 1'b0, 1'b0, 16'h1234);
    bus_wr(20'h00005, 16'hFF77, 1'b1, 1'b0);
    bus_rd("rd_5_lo_write", 20'h00005, 1'b0, 1'b0, 16'h1277);
    bus_rd("rd_5_upper_only", 20'h00005, 1'b0, 1'b1, 16'h12FF);
    bus_wr(20'h00010, 16'h0006, 1'b0, 1'b0);
    bus_rd("rd_10_after_wr", 20'h00010, 1'b0, 1'b0, 16'h0006);

    ce = 1'b0; oe = 1'b0; we = 1'b0; ub = 1'b0; lb = 1'b1; addr = 20'h00020;
    expect_now("we_oe_no_drive", HIZ, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    bus_rd("rd_20_upper_lane", 20'h00020, 1'b0, 1'b0, 16'hFF00);

    bus_wr(20'h00400, 16'h1234, 1'b0, 1'b0);
    err_exp = 1'b1;
    bus_rd("rd_oor", 20'h00400, 1'b0, 1'b0, 16'h0000);
    bus_rd("rd_0_unchanged", 20'h00000, 1'b0, 1'b0, 16'h0000);
    bus_wr(20'h00001, 16'h5555, 1'b0, 1'b0);
    bus_rd("rd_1_err_sticky", 20'h00001, 1'b0, 1'b0, 16'h5555);

    ce = 1'b0; oe = 1'b0; we = 1'b1; addr = 20'h00001;
    step();
    rst_n = 1'b0;
    err_exp = 1'b0;
    expect_now("reset_mid_serve", HIZ, 1'b1, 1'b0, 1'b0);
    idle();
    step();
    rst_n = 1'b1;
    repeat (1024) step();
    expect_now("reclear_ready", HIZ, 1'b1, 1'b1, 1'b0);
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    bus_rd("rd_1_after_reclear", 20'h00001, 1'b0, 1'b0, 16'h0000);

    step();
    step();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d unchecked entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
